dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the processor's data bus (proc2Dmem_addr / proc2Dmem_command / proc2mem_data in, mem2proc_data out).
- Models a single-port word SRAM. A posted store buffer frees the array port so loads always complete combinationally in the same cycle.
- A secondary host port lets the testbench or loader read and write memory coherently with in-flight stores.

Parameters:
- ADDR_W, 12, word-index width; array depth = 2**ADDR_W words of 32 bits
- SB_DEPTH, 4, store-buffer entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- proc2Dmem_addr  in  32  byte address; word index = addr[ADDR_W+1:2]; other bits ignored
- proc2Dmem_command  in  2  `BUS_NONE / `BUS_LOAD / `BUS_STORE (sys_defs.vh)
- proc2mem_data  in  32  store data
- mem2proc_data  out  32  load data, combinational
- host_req  in  1  host access request; held until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  word index
- host_wdata  in  32  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  32  read data; valid while host_ack=1, held afterwards
- sb_count  out  $clog2(SB_DEPTH)+1  store-buffer occupancy

Behaviour:
- Reset: store buffer empty (head=tail=0, sb_count=0), FSM=IDLE, host_ack=0, host_rdata=0. Array contents are not reset.
- Array: one port per cycle, used by exactly one of: processor load read, store-buffer drain write, host access.
- Port arbitration each cycle:
  - command=LOAD: port serves the load.
  - command=STORE: port drains the buffer head, if any.
  - command=NONE, buffer non-empty: port drains.
  - command=NONE, buffer empty, FSM=IDLE, host_req=1: port grants the host.
- Load: mem2proc_data = data of the youngest buffer entry whose word index matches; otherwise array[index]. Zero-latency, combinational.
- mem2proc_data = 0 whenever command != LOAD.
- Store: {index, data} enqueued at the tail on the clock edge. Drain pops the entry at the head before the edge, so a store is never drained in its arrival cycle.
- Full buffer + STORE: pop and push occur in the same edge; no overflow is possible, because a STORE cycle always drains.
- Empty buffer + STORE: push only; sb_count becomes 1.
- Simultaneous push and pop: sb_count unchanged. Pointers wrap modulo SB_DEPTH.
- Illegal command encoding: treated as NONE.
- Host FSM states:
  - IDLE: on grant, perform the access (write: array<=host_wdata; read: host_rdata<=array[host_addr]); go to ACK.
  - ACK: host_ack=1 for exactly one cycle; go to IDLE.
  - host_req still high in the first IDLE cycle after ACK counts as a new request.
- Host never sees stale data: grant requires an empty buffer, so all prior processor stores are visible.
- Processor always has priority over the host. The host may wait indefinitely under continuous LOAD/STORE traffic.
- Reset mid-operation: buffered stores are discarded, the FSM aborts to IDLE, and no host_ack is issued.

Optional Feature:
- Macro DMEM_STATS_EN.
- Defined: adds 32-bit outputs stat_loads, stat_stores, stat_fwd_hits. They count LOAD cycles, STORE cycles, and loads served from the store buffer. Saturating, reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load after reset: host write 0x0000_1234 to index 5 (ack after 2 cycles); processor LOAD addr 0x14 -> mem2proc_data=0x0000_1234 same cycle; command NONE -> 0.
- Forwarding: STORE 0xAAAA_0001 to 0x40, then LOAD 0x40 next cycle -> 0xAAAA_0001 from buffer, sb_count=1; NONE cycle -> sb_count=0, array[16]=0xAAAA_0001.
- Youngest match: STOREs to 0x40 with 1, 2, 3 back-to-back, then LOAD 0x40 -> 3; drain via NONE cycles, final array[16]=3.
- Host blocked by traffic: host_req read of index 16 during 10 LOAD cycles -> host_ack stays 0; first NONE cycle with empty buffer grants; host_ack pulses the next cycle with host_rdata=3.
- Wrap/full stress: 20 consecutive STOREs to indices 0..19 (data=index) with SB_DEPTH=4 -> sb_count never exceeds SB_DEPTH, no lost store; after drain, host reads of 0..19 return 0..19.
- Async reset mid-traffic: assert rst with sb_count=1 and FSM=ACK -> sb_count=0, host_ack=0 immediately; the discarded store is not written (array word unchanged).

Source files
------------

// File: rtl/dmem_responder_if.sv
// Processor data-bus and host-port bundle for dmem_responder.
// The stat_* counters exist only when DMEM_STATS_EN is defined.
`timescale 1ns/1ps
interface dmem_responder_if #(
   parameter int ADDR_W   = 12,
   parameter int SB_DEPTH = 4
);
   localparam int CNT_W = $clog2(SB_DEPTH) + 1;

   logic [31:0]       proc2Dmem_addr;
   logic [1:0]        proc2Dmem_command;
   logic [31:0]       proc2mem_data;
   logic [31:0]       mem2proc_data;
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [31:0]       host_wdata;
   logic              host_ack;
   logic [31:0]       host_rdata;
   logic [CNT_W-1:0]  sb_count;
`ifdef DMEM_STATS_EN
   logic [31:0]       stat_loads;
   logic [31:0]       stat_stores;
   logic [31:0]       stat_fwd_hits;

   modport master (
      output proc2Dmem_addr, proc2Dmem_command, proc2mem_data,
      output host_req, host_we, host_addr, host_wdata,
      input  mem2proc_data, host_ack, host_rdata, sb_count,
      input  stat_loads, stat_stores, stat_fwd_hits
   );
   modport slave (
      input  proc2Dmem_addr, proc2Dmem_command, proc2mem_data,
      input  host_req, host_we, host_addr, host_wdata,
      output mem2proc_data, host_ack, host_rdata, sb_count,
      output stat_loads, stat_stores, stat_fwd_hits
   );
`else
   modport master (
      output proc2Dmem_addr, proc2Dmem_command, proc2mem_data,
      output host_req, host_we, host_addr, host_wdata,
      input  mem2proc_data, host_ack, host_rdata, sb_count
   );
   modport slave (
      input  proc2Dmem_addr, proc2Dmem_command, proc2mem_data,
      input  host_req, host_we, host_addr, host_wdata,
      output mem2proc_data, host_ack, host_rdata, sb_count
   );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Single-port word SRAM data-memory responder with posted store buffer and host port.
// Optional load/store/forward-hit counters are enabled with DMEM_STATS_EN.
//
// state | meaning
// IDLE  | host port may be granted when the bus is NONE and the store buffer is empty
// ACK   | host access done; host_ack high for this one cycle
`timescale 1ns/1ps
module dmem_responder #(
   parameter int ADDR_W   = 12,
   parameter int SB_DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   dmem_responder_if.slave  bus
);
   localparam logic [1:0] BUS_LOAD  = 2'h1;
   localparam logic [1:0] BUS_STORE = 2'h2;
   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] sb_idx  [0:SB_DEPTH-1];
   logic [31:0]       sb_data [0:SB_DEPTH-1];
   logic [PTR_W-1:0]  head, tail;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] proc_idx;
   logic              is_load, is_store, drain, host_grant;
   logic              fwd_hit;
   logic [31:0]       fwd_data;
   logic [31:0]       rdata_q;
   logic              unused_addr_bits;

   assign proc_idx         = bus.proc2Dmem_addr[ADDR_W+1:2];
   assign unused_addr_bits = ^{bus.proc2Dmem_addr[31:ADDR_W+2], bus.proc2Dmem_addr[1:0]};
   assign is_load          = (bus.proc2Dmem_command == BUS_LOAD);
   assign is_store         = (bus.proc2Dmem_command == BUS_STORE);
   // Any non-LOAD cycle owns the port for draining; illegal encodings behave as NONE.
   assign drain            = !is_load && (count != '0);
   assign host_grant       = !rst && !is_load && !is_store && (count == '0)
                             && (state == IDLE) && bus.host_req;

   // Walk oldest to youngest so the youngest matching entry wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if ((CNT_W'(i) < count) && (sb_idx[head + PTR_W'(i)] == proc_idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = sb_data[head + PTR_W'(i)];
         end
      end
   end

   assign bus.mem2proc_data = is_load ? (fwd_hit ? fwd_data : mem[proc_idx]) : 32'h0;
   assign bus.sb_count      = count;
   assign bus.host_rdata    = rdata_q;

   always_ff @(posedge clk) begin
      if (drain)
         mem[sb_idx[head]] <= sb_data[head];
      else if (host_grant && bus.host_we)
         mem[bus.host_addr] <= bus.host_wdata;
   end

   always_ff @(posedge clk) begin
      if (is_store) begin
         sb_idx[tail]  <= proc_idx;
         sb_data[tail] <= bus.proc2mem_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (drain)    head <= head + 1'b1;
         if (is_store) tail <= tail + 1'b1;
         case ({is_store, drain})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            rdata_q <= '0;
      else if (host_grant && !bus.host_we) rdata_q <= mem[bus.host_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      bus.host_ack = 1'b0;
      case (state)
         IDLE: if (host_grant) state_nxt = ACK;
         ACK: begin
            bus.host_ack = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef DMEM_STATS_EN
   logic [31:0] stat_loads_q, stat_stores_q, stat_fwd_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_loads_q  <= '0;
         stat_stores_q <= '0;
         stat_fwd_q    <= '0;
      end else begin
         if (is_load && (stat_loads_q != '1))             stat_loads_q  <= stat_loads_q + 1'b1;
         if (is_store && (stat_stores_q != '1))           stat_stores_q <= stat_stores_q + 1'b1;
         if (is_load && fwd_hit && (stat_fwd_q != '1))    stat_fwd_q    <= stat_fwd_q + 1'b1;
      end
   end

   assign bus.stat_loads    = stat_loads_q;
   assign bus.stat_stores   = stat_stores_q;
   assign bus.stat_fwd_hits = stat_fwd_q;
`endif
endmodule
